uart_frame_ctrl: RTL and testbench

//  Parametrised framing controller between uart_rx, the accelerator and uart_tx.

---
 rtl/uart_accel_pkg.sv | 17 +
 rtl/uart_frame_ctrl_idle_timer.sv | 48 ++++
 rtl/uart_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_accel_pkg.sv
// Shared definitions for the UART accelerator framing path: byte width and
// the frame controller's state encoding.
package uart_accel_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_LAUNCH,
        ST_COMPUTE,
        ST_TX_SEND,
        ST_TX_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/uart_frame_ctrl_idle_timer.sv
// Inter-byte idle timer. Counts enabled cycles since the last clear and raises
// a one-cycle expired pulse on the cycle whose edge would bring the count to MAX.
// A clear in that same cycle suppresses expiry. MAX = 0 disables the timer.
module idle_timer #(
    parameter int unsigned MAX = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (MAX == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, enable};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(MAX + 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Next count: restart on clear or when disabled, saturate at MAX
            always_comb begin
                cnt_d = cnt_q;
                if (clear || !enable) begin
                    cnt_d = '0;
                end else if (cnt_q != CW'(MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Count register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = enable && !clear && (cnt_q == CW'(MAX - 1));
        end
    endgenerate

endmodule

// File: rtl/uart_frame_ctrl.sv
// Framing controller: gathers operand bytes from uart_rx, launches the
// accelerator, then returns the result to uart_tx one byte at a time (LSB first).
module uart_frame_ctrl
    import uart_accel_pkg::*;
#(
    parameter int NUM_OPERANDS   = 2,
    parameter int OPERAND_BYTES  = 1,
    parameter int RESULT_BYTES   = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        rx_valid,
    input  logic [7:0]                                  rx_data,
    output logic                                        acc_start,
    output logic [NUM_OPERANDS*8*OPERAND_BYTES-1:0]     acc_operands,
    input  logic                                        acc_done,
    input  logic [RESULT_BYTES*8-1:0]                   acc_result,
    output logic                                        tx_start,
    output logic [7:0]                                  tx_data,
    input  logic                                        tx_done,
    output logic [RESULT_BYTES*8-1:0]                   result_q,
    output logic                                        busy,
    output logic [7:0]                                  frame_count,
    output logic                                        timeout_err,
    output logic                                        overrun_err
);

    localparam int N     = NUM_OPERANDS * OPERAND_BYTES;
    localparam int OPS_W = N * BYTE_W;
    localparam int RES_W = RESULT_BYTES * BYTE_W;
    localparam int BCW   = $clog2(N + 1);
    localparam int TCW   = $clog2(RESULT_BYTES + 1);

    state_t             state_q, state_d;
    logic [OPS_W-1:0]   ops_q, ops_d;
    logic [BCW-1:0]     bcnt_q, bcnt_d;
    logic [TCW-1:0]     idx_q, idx_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         fcnt_q, fcnt_d;
    logic               to_err_q, to_err_d;
    logic               ov_err_q, ov_err_d;
    logic               timer_expired;

    idle_timer #(
        .MAX (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_valid),
        .enable  (state_q == ST_RX),
        .expired (timer_expired)
    );

    // Next-state, datapath updates and sticky error flags
    always_comb begin
        state_d    = state_q;
        ops_d      = ops_q;
        bcnt_d     = bcnt_q;
        idx_d      = idx_q;
        res_d      = res_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        fcnt_d     = fcnt_q;
        to_err_d   = to_err_q;
        ov_err_d   = ov_err_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    // Previous frame's operands stay visible until this first byte.
                    ops_d               = '0;
                    ops_d[BYTE_W-1:0]   = rx_data;
                    bcnt_d              = BCW'(1);
                    state_d             = (N == 1) ? ST_LAUNCH : ST_RX;
                end
            end
            ST_RX: begin
                if (rx_valid) begin
                    ops_d[BYTE_W*bcnt_q +: BYTE_W] = rx_data;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BCW'(N - 1)) begin
                        state_d = ST_LAUNCH;
                    end
                end else if (timer_expired) begin
                    ops_d    = '0;
                    bcnt_d   = '0;
                    to_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                // acc_done is deliberately not looked at while acc_start is high.
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (acc_done) begin
                    res_d   = acc_result;
                    idx_d   = '0;
                    state_d = ST_TX_SEND;
                end
            end
            ST_TX_SEND: begin
                tx_data_d  = res_q[BYTE_W*idx_q +: BYTE_W];
                tx_start_d = 1'b1;
                state_d    = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (tx_done) begin
                    if (idx_q == TCW'(RESULT_BYTES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_TX_SEND;
                    end
                end
            end
            ST_DONE: begin
                fcnt_d  = fcnt_q + 8'd1;
                bcnt_d  = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bytes arriving after the operands are complete are dropped and flagged.
        if (rx_valid && (state_q != ST_IDLE) && (state_q != ST_RX)) begin
            ov_err_d = 1'b1;
        end
    end

    // State and datapath registers; reset discards any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ops_q      <= '0;
            bcnt_q     <= '0;
            idx_q      <= '0;
            res_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            fcnt_q     <= '0;
            to_err_q   <= 1'b0;
            ov_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ops_q      <= ops_d;
            bcnt_q     <= bcnt_d;
            idx_q      <= idx_d;
            res_q      <= res_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            fcnt_q     <= fcnt_d;
            to_err_q   <= to_err_d;
            ov_err_q   <= ov_err_d;
        end
    end

    assign acc_start    = (state_q == ST_LAUNCH);
    assign acc_operands = ops_q;
    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign result_q     = res_q;
    assign busy         = (state_q != ST_IDLE);
    assign frame_count  = fcnt_q;
    assign timeout_err  = to_err_q;
    assign overrun_err  = ov_err_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomised bench for uart_frame_ctrl with 2x16-bit operands, 16-bit result
// and a 100-cycle inter-byte timeout, checked against a frame-level model.
module tb_uart_frame_ctrl;

    localparam int NUM_OPS = 2;
    localparam int OB      = 2;
    localparam int RB      = 2;
    localparam int TO      = 100;
    localparam int N       = NUM_OPS * OB;
    localparam int OPS_W   = N * 8;
    localparam int RES_W   = RB * 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               acc_start;
    logic [OPS_W-1:0]   acc_operands;
    logic               acc_done;
    logic [RES_W-1:0]   acc_result;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_done;
    logic [RES_W-1:0]   result_q;
    logic               busy;
    logic [7:0]         frame_count;
    logic               timeout_err;
    logic               overrun_err;

    int n_vec = 0;
    int n_bad = 0;

    // Observed pulse counts and transmitted bytes
    int         acc_cnt = 0;
    int         tx_cnt  = 0;
    logic [7:0] txq[$];

    // Model state
    int m_acc = 0;
    int m_tx  = 0;
    int m_fc  = 0;
    bit m_to  = 1'b0;
    bit m_ov  = 1'b0;

    uart_frame_ctrl #(
        .NUM_OPERANDS   (NUM_OPS),
        .OPERAND_BYTES  (OB),
        .RESULT_BYTES   (RB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .acc_start    (acc_start),
        .acc_operands (acc_operands),
        .acc_done     (acc_done),
        .acc_result   (acc_result),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .result_q     (result_q),
        .busy         (busy),
        .frame_count  (frame_count),
        .timeout_err  (timeout_err),
        .overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampling shortly after each active edge
    always @(posedge clk) begin
        #2;
        if (acc_start === 1'b1) acc_cnt++;
        if (tx_start === 1'b1) begin
            tx_cnt++;
            txq.push_back(tx_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string p);
        chk({p, ":acc_start"},    64'(acc_start),    64'(0));
        chk({p, ":acc_operands"}, 64'(acc_operands), 64'(0));
        chk({p, ":tx_start"},     64'(tx_start),     64'(0));
        chk({p, ":tx_data"},      64'(tx_data),      64'(0));
        chk({p, ":result_q"},     64'(result_q),     64'(0));
        chk({p, ":busy"},         64'(busy),         64'(0));
        chk({p, ":frame_count"},  64'(frame_count),  64'(0));
        chk({p, ":timeout_err"},  64'(timeout_err),  64'(0));
        chk({p, ":overrun_err"},  64'(overrun_err),  64'(0));
    endtask

    // gap_mode: 0 short random gaps, 1 every gap at the timeout limit, 2 mixed
    task automatic run_frame(input int gap_mode, input bit overrun, input int hold,
                             input bit abort_tx);
        logic [OPS_W-1:0] exp_ops;
        logic [RES_W-1:0] res;
        logic [7:0]       b;
        logic [7:0]       got_b;
        logic [7:0]       exp_b;
        int               gap;
        int               budget;

        exp_ops = '0;
        for (int i = 0; i < N; i++) begin
            b = 8'($urandom);
            exp_ops = exp_ops | (OPS_W'(b) << (8 * i));
            if (i > 0) begin
                if (gap_mode == 1)
                    gap = TO - 1;
                else if (gap_mode == 2 && $urandom_range(0, 3) == 0)
                    gap = TO - 1;
                else
                    gap = $urandom_range(0, 3);
                repeat (gap) tick();
            end
            send_byte(b);
        end

        m_acc++;
        chk("acc_start_after_last_byte", 64'(acc_start), 64'(1));
        chk("acc_operands", 64'(acc_operands), 64'(exp_ops));
        tick();
        chk("acc_start_one_cycle", 64'(acc_start), 64'(0));
        chk("acc_start_count", 64'(acc_cnt), 64'(m_acc));

        if (overrun) begin
            send_byte(8'($urandom));
            m_ov = 1'b1;
            chk("overrun_flag", 64'(overrun_err), 64'(1));
            chk("overrun_ops_kept", 64'(acc_operands), 64'(exp_ops));
        end

        res        = RES_W'($urandom);
        acc_result = res;
        acc_done   = 1'b1;
        repeat (hold) tick();
        acc_done   = 1'b0;
        acc_result = RES_W'($urandom);

        for (int i = 0; i < RB; i++) begin
            budget = 0;
            while (txq.size() == 0 && budget < 20) begin
                tick();
                budget++;
            end
            if (txq.size() == 0) begin
                chk("tx_start_seen", 64'(0), 64'(1));
                return;
            end
            m_tx++;
            got_b = txq.pop_front();
            exp_b = 8'(res >> (8 * i));
            chk("tx_byte", 64'(got_b), 64'(exp_b));

            if (abort_tx) begin
                reset = 1'b1;
                #1;
                chk_zero_outputs("reset_in_tx_wait");
                m_fc = 0;
                m_to = 1'b0;
                m_ov = 1'b0;
                tick();
                reset = 1'b0;
                tick();
                return;
            end

            repeat ($urandom_range(1, 3)) tick();
            chk("tx_start_waits_for_done", 64'(tx_cnt), 64'(m_tx));
            chk("tx_data_held", 64'(tx_data), 64'(exp_b));
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end

        budget = 0;
        while (busy === 1'b1 && budget < 10) begin
            tick();
            budget++;
        end
        m_fc = (m_fc + 1) % 256;
        chk("busy_end", 64'(busy), 64'(0));
        chk("frame_count", 64'(frame_count), 64'(m_fc));
        chk("result_q", 64'(result_q), 64'(res));
        chk("operands_held", 64'(acc_operands), 64'(exp_ops));
        chk("timeout_err", 64'(timeout_err), 64'(m_to));
        chk("overrun_err", 64'(overrun_err), 64'(m_ov));
        chk("tx_count", 64'(tx_cnt), 64'(m_tx));
        chk("acc_count", 64'(acc_cnt), 64'(m_acc));
    endtask

    task automatic timeout_case();
        send_byte(8'($urandom) | 8'h01);
        repeat (TO - 1) tick();
        chk("timeout_not_yet_busy", 64'(busy), 64'(1));
        chk("timeout_not_yet_flag", 64'(timeout_err), 64'(m_to));
        tick();
        m_to = 1'b1;
        chk("timeout_idle", 64'(busy), 64'(0));
        chk("timeout_flag", 64'(timeout_err), 64'(1));
        chk("timeout_ops_cleared", 64'(acc_operands), 64'(0));
        chk("timeout_no_start", 64'(acc_cnt), 64'(m_acc));
    endtask

    initial begin
        reset      = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = '0;
        acc_done   = 1'b0;
        acc_result = '0;
        tx_done    = 1'b0;
        repeat (3) tick();
        chk_zero_outputs("reset_state");
        reset = 1'b0;
        tick();

        run_frame(0, 1'b0, 1, 1'b0);
        run_frame(1, 1'b0, 3, 1'b0);
        timeout_case();
        run_frame(2, 1'b0, 2, 1'b0);
        run_frame(0, 1'b1, 1, 1'b0);
        run_frame(0, 1'b0, 3, 1'b0);
        run_frame(0, 1'b0, 2, 1'b1);

        // 256 frames since the reset above: counter must wrap back to 0
        for (int f = 0; f < 256; f++) begin
            run_frame(0, 1'b0, $urandom_range(1, 3), 1'b0);
        end
        chk("frame_count_wrap", 64'(frame_count), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
